pc_counter: RTL and testbench

Parametrised program-counter register, the multi-bit successor of the single-bit `dff` storage cell. It holds a WIDTH-bit address and each clock either holds, increments by STEP, loads an absolute target (capturing a link/return address), or adds a signed relative offset. It exports true and complemented outputs (`q`/`nq`, as the `dff` cell does) plus a wrap flag, and feeds the instruction-memory address bus.

---
 rtl/pc_counter.sv | 84 ++++++++
 tb/tb_pc_counter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/pc_counter.sv
// Program-counter register: hold, increment by STEP, absolute load with link capture,
// or signed relative branch, with complemented copy and a one-cycle wrap pulse.
module pc_counter #(
   parameter int unsigned     WIDTH     = 8,
   parameter int unsigned     STEP      = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] nq,
   output logic [WIDTH-1:0] link,
   output logic             wrap
);

   localparam int unsigned SUM_W = WIDTH + 1;

   typedef enum logic [1:0] {
      MODE_HOLD = 2'b00,
      MODE_INC  = 2'b01,
      MODE_LOAD = 2'b10,
      MODE_REL  = 2'b11
   } mode_e;

   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] nq_q, nq_d;
   logic [WIDTH-1:0] link_q, link_d;
   logic             wrap_q, wrap_d;
   logic [SUM_W-1:0] inc_sum;
   logic [SUM_W-1:0] rel_sum;

   // With the offset sign-extended into the extra bit, bit WIDTH of the sum is set
   // exactly when the true result falls outside 0..2^WIDTH-1, for either sign of d.
   assign inc_sum = {1'b0, q_q} + SUM_W'(STEP);
   assign rel_sum = {1'b0, q_q} + {d[WIDTH-1], d};

   always_comb begin
      q_d    = q_q;
      link_d = link_q;
      wrap_d = 1'b0;
      if (en) begin
         unique case (mode_e'(mode))
            MODE_HOLD: q_d = q_q;
            MODE_INC: begin
               q_d    = inc_sum[WIDTH-1:0];
               wrap_d = inc_sum[WIDTH];
            end
            MODE_LOAD: begin
               q_d    = d;
               link_d = inc_sum[WIDTH-1:0];
            end
            MODE_REL: begin
               q_d    = rel_sum[WIDTH-1:0];
               wrap_d = rel_sum[WIDTH];
            end
            default: q_d = q_q;
         endcase
      end
      nq_d = ~q_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q    <= RESET_VAL;
         nq_q   <= ~RESET_VAL;
         link_q <= '0;
         wrap_q <= 1'b0;
      end else begin
         q_q    <= q_d;
         nq_q   <= nq_d;
         link_q <= link_d;
         wrap_q <= wrap_d;
      end
   end

   assign q    = q_q;
   assign nq   = nq_q;
   assign link = link_q;
   assign wrap = wrap_q;

endmodule

// File: tb/tb_pc_counter.sv
// Scoreboard bench for pc_counter: directed vectors push expected state, a monitor
// pops and compares after each rising clock edge or asynchronous reset assertion.
module tb_pc_counter;

   localparam logic [1:0] M_HOLD = 2'b00;
   localparam logic [1:0] M_INC  = 2'b01;
   localparam logic [1:0] M_LOAD = 2'b10;
   localparam logic [1:0] M_REL  = 2'b11;

   typedef struct {
      bit         sel;
      logic [7:0] q;
      logic [7:0] link;
      logic       wrap;
      string      tag;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en  = 1'b0;
   logic [1:0] mode = M_HOLD;
   logic [7:0] d = 8'h00;

   logic [7:0] qa, nqa, linka, qb, nqb, linkb;
   logic       wrapa, wrapb;

   exp_t sb[$];
   int   chk_cnt  = 0;
   int   pass_cnt = 0;

   always #5 clk = ~clk;

   pc_counter #(.WIDTH(8), .STEP(1), .RESET_VAL(8'h00)) u_dut_a (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
      .q(qa), .nq(nqa), .link(linka), .wrap(wrapa)
   );

   pc_counter #(.WIDTH(8), .STEP(4), .RESET_VAL(8'h10)) u_dut_b (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
      .q(qb), .nq(nqb), .link(linkb), .wrap(wrapb)
   );

   task automatic compare(input string name, input logic [7:0] act, input logic [7:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
   endtask

   task automatic push(input bit sel, input logic [7:0] eq, input logic [7:0] el,
                       input logic ew, input string tag);
      exp_t e;
      e.sel = sel; e.q = eq; e.link = el; e.wrap = ew; e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic op(input logic e, input logic [1:0] m, input logic [7:0] dv,
                     input logic [7:0] eq, input logic [7:0] el, input logic ew,
                     input string tag);
      @(negedge clk);
      en = e; mode = m; d = dv;
      push(1'b0, eq, el, ew, tag);
   endtask

   // Monitor: the DUT presents new state after each rising edge or reset assertion
   initial begin
      forever begin
         @(posedge clk or posedge rst);
         #1;
         while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            if (!e.sel) begin
               compare({e.tag, ".q"},    qa,    e.q);
               compare({e.tag, ".nq"},   nqa,   ~e.q);
               compare({e.tag, ".link"}, linka, e.link);
               compare({e.tag, ".wrap"}, 8'(wrapa), 8'(e.wrap));
            end else begin
               compare({e.tag, ".b.q"},    qb,    e.q);
               compare({e.tag, ".b.nq"},   nqb,   ~e.q);
               compare({e.tag, ".b.link"}, linkb, e.link);
               compare({e.tag, ".b.wrap"}, 8'(wrapb), 8'(e.wrap));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t, limit 200000", $time);
      $fatal(1);
   end

   initial begin
      // Reset state for both parameterisations
      @(negedge clk);
      push(1'b0, 8'h00, 8'h00, 1'b0, "reset");
      push(1'b1, 8'h10, 8'h00, 1'b0, "reset");

      // Release and count
      @(negedge clk);
      rst = 1'b0; en = 1'b1; mode = M_INC; d = 8'h00;
      push(1'b0, 8'h01, 8'h00, 1'b0, "inc1");
      op(1'b1, M_INC, 8'h00, 8'h02, 8'h00, 1'b0, "inc2");
      op(1'b1, M_INC, 8'h00, 8'h03, 8'h00, 1'b0, "inc3");
      op(1'b1, M_INC, 8'h00, 8'h04, 8'h00, 1'b0, "inc4");
      op(1'b1, M_INC, 8'h00, 8'h05, 8'h00, 1'b0, "inc5");

      // Increment wrap
      op(1'b1, M_LOAD, 8'hFE, 8'hFE, 8'h06, 1'b0, "ld_fe");
      op(1'b1, M_INC,  8'h00, 8'hFF, 8'h06, 1'b0, "inc_ff");
      op(1'b1, M_INC,  8'h00, 8'h00, 8'h06, 1'b1, "inc_wrap");
      op(1'b1, M_HOLD, 8'h00, 8'h00, 8'h06, 1'b0, "hold_after_wrap");

      // Load captures pre-edge q + STEP
      op(1'b1, M_LOAD, 8'h10, 8'h10, 8'h01, 1'b0, "ld_10");
      op(1'b1, M_LOAD, 8'h80, 8'h80, 8'h11, 1'b0, "ld_80");
      op(1'b1, M_INC,  8'h00, 8'h81, 8'h11, 1'b0, "inc_link_keep");

      // Relative branches
      op(1'b1, M_LOAD, 8'h20, 8'h20, 8'h82, 1'b0, "ld_20");
      op(1'b1, M_REL,  8'hFC, 8'h1C, 8'h82, 1'b0, "rel_back");
      op(1'b1, M_LOAD, 8'h02, 8'h02, 8'h1D, 1'b0, "ld_02");
      op(1'b1, M_REL,  8'hFC, 8'hFE, 8'h1D, 1'b1, "rel_under");
      op(1'b1, M_LOAD, 8'hF0, 8'hF0, 8'hFF, 1'b0, "ld_f0");
      op(1'b1, M_REL,  8'h20, 8'h10, 8'hFF, 1'b1, "rel_over");
      op(1'b1, M_REL,  8'hF0, 8'h00, 8'hFF, 1'b0, "rel_to_zero");

      // Back-to-back wrapping updates keep wrap high
      op(1'b1, M_LOAD, 8'hFF, 8'hFF, 8'h01, 1'b0, "ld_ff");
      op(1'b1, M_INC,  8'h00, 8'h00, 8'h01, 1'b1, "b2b_inc");
      op(1'b1, M_REL,  8'hFF, 8'hFF, 8'h01, 1'b1, "b2b_rel");

      // Enable low freezes state and clears wrap
      op(1'b0, M_INC,  8'h00, 8'hFF, 8'h01, 1'b0, "en0_clear_wrap");
      op(1'b1, M_LOAD, 8'h33, 8'h33, 8'h00, 1'b0, "ld_33");
      op(1'b0, M_INC,  8'h00, 8'h33, 8'h00, 1'b0, "en0_a");
      op(1'b0, M_INC,  8'h00, 8'h33, 8'h00, 1'b0, "en0_b");
      op(1'b0, M_LOAD, 8'h99, 8'h33, 8'h00, 1'b0, "en0_load");
      op(1'b1, M_HOLD, 8'h55, 8'h33, 8'h00, 1'b0, "hold_en1");

      // Asynchronous reset between edges
      op(1'b1, M_LOAD, 8'h47, 8'h47, 8'h34, 1'b0, "ld_47");
      @(negedge clk);
      en = 1'b0; mode = M_HOLD;
      push(1'b0, 8'h00, 8'h00, 1'b0, "async_rst");
      push(1'b1, 8'h10, 8'h00, 1'b0, "async_rst");
      #2 rst = 1'b1;

      // Release and step both instances
      @(negedge clk);
      rst = 1'b0; en = 1'b1; mode = M_INC;
      push(1'b0, 8'h01, 8'h00, 1'b0, "post_rst_inc1");
      push(1'b1, 8'h14, 8'h00, 1'b0, "post_rst_inc1");
      @(negedge clk);
      push(1'b0, 8'h02, 8'h00, 1'b0, "post_rst_inc2");
      push(1'b1, 8'h18, 8'h00, 1'b0, "post_rst_inc2");

      @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      compare("scoreboard_drained", 8'(sb.size()), 8'h00);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
